pwm_breath: RTL and testbench
=============================

PWM_BREATH -- requirements
Module: pwm_breath

Interface
REQ-001 The parameter STEP SHALL default to 1 and set the duty increment/decrement per PWM period (legal range 1..128).
REQ-002 The parameter HOLD_PERIODS SHALL default to 16 and set the number of PWM periods spent at full/zero duty (legal range 1..255).
REQ-003 The port sclk SHALL be an input of width 1 and serve as the single clock; all state SHALL be updated on its rising edge.
REQ-004 The port rst_n SHALL be an input of width 1 and serve as the asynchronous, active-low reset.
REQ-005 The port en SHALL be an input of width 1 that enables breathing operation.
REQ-006 The port cnt_in SHALL be an input of width 8 that carries the upstream free-running period count, wrapping 0..255.
REQ-007 The port pwm_out SHALL be an output of width 1 that carries the registered PWM waveform.
REQ-008 The port duty SHALL be an output of width 8 that reports the current duty value.
REQ-009 The port period_tick SHALL be an output of width 1 that pulses for one cycle per PWM period.
REQ-010 The port dir SHALL be an output of width 1 that reports the ramp direction: 0 while rising or holding low, 1 while falling or holding high.

Function
REQ-011 The block SHALL implement the states IDLE, RISE, HOLD_HI, FALL and HOLD_LO.
REQ-012 The block SHALL register period_tick high for exactly one cycle on the edge following a sample of cnt_in==8'd255, so that the pulse coincides with cnt_in==0; it SHALL do so only when en=1.
REQ-013 The block SHALL update duty on that same edge, so that each new duty value takes effect from cnt_in==0.
REQ-014 The block SHALL compute pwm_out <= en && (cnt_in < duty) with one cycle of latency: duty=0 gives a constant low, and duty=255 gives 255 high cycles out of 256.
REQ-015 When in IDLE with en=1, the block SHALL move to RISE on the next edge with duty=0.
REQ-016 In RISE, each period step SHALL set duty to duty+STEP; if duty > 255-STEP, duty SHALL saturate at 255 and the state SHALL move to HOLD_HI with dir=1.
REQ-017 In FALL, each period step SHALL set duty to duty-STEP; if duty < STEP, duty SHALL saturate at 0 and the state SHALL move to HOLD_LO with dir=0.
REQ-018 Duty arithmetic SHALL use a 9-bit intermediate so that no wrap-around reaches duty.
REQ-019 In HOLD_HI and HOLD_LO, the block SHALL count period ticks; after HOLD_PERIODS ticks it SHALL move to FALL or RISE respectively, and the hold counter SHALL clear on every state entry.
REQ-020 When en is deasserted in any state, on the next edge the block SHALL enter IDLE and set duty=0, dir=0, hold counter=0 and pwm_out=0; no partial period completion SHALL occur.
REQ-021 If en rises on a cycle with cnt_in==255, the block SHALL still enter RISE first and SHALL NOT issue a period step on that edge.
REQ-022 cnt_in SHALL be trusted as a monotonic wrap counter; a jump that skips 255 SHALL simply produce no tick.

Reset
REQ-023 While rst_n=0, the block SHALL immediately and asynchronously force state=IDLE, duty=0, dir=0, pwm_out=0, period_tick=0 and hold counter=0.
REQ-024 A reset asserted mid-ramp SHALL discard all progress, and breathing SHALL restart from duty=0 once rst_n=1 and en=1.

Configuration
REQ-025 With BREATH_HOLD_EN defined, the HOLD_HI and HOLD_LO states and the hold counter SHALL be present as described above.
REQ-026 Without BREATH_HOLD_EN, the block SHALL go directly from RISE to FALL on reaching 255 and from FALL to RISE on reaching 0, the hold logic SHALL be absent, and HOLD_PERIODS SHALL be ignored.

Structure
REQ-027 The shared package pwm_breath_pkg SHALL hold the state encoding constants (3-bit IDLE/RISE/HOLD_HI/FALL/HOLD_LO), the 8-bit count width constant and the DUTY_MAX=255 constant.
REQ-028 The block SHALL contain one sub-module, pwm_cmp, which performs the registered comparison of cnt_in against duty and is gated by en.
REQ-029 The FSM, duty arithmetic and tick detection SHALL remain in pwm_breath.

Verification
REQ-030 Reset then release: rst_n=0 for 3 cycles with en=1 and cnt_in counting -> all outputs 0 throughout reset, and the state leaves IDLE on the first edge after release.
REQ-031 STEP=1, en=1, cnt_in 0..255 free-running -> after the first wrap duty=1 and pwm_out is high exactly 1 cycle per 256, beginning 1 cycle after cnt_in==0.
REQ-032 STEP=16, BREATH_HOLD_EN defined, HOLD_PERIODS=2 -> duty follows 16, 32, ..., 240, 255; 2 periods at 255 with dir=1; then 239 ... 15, 0; 2 periods at 0; then 16 again.
REQ-033 BREATH_HOLD_EN undefined, STEP=128 -> duty follows 128, 255, 127, 0, 128 on successive period ticks.
REQ-034 en dropped while duty=100 and cnt_in=50 -> the next edge gives pwm_out=0 and duty=0; re-asserting en restarts from duty=0 with dir=0.
REQ-035 en rises on the cycle with cnt_in==255 -> no period_tick and no duty step on that edge; the first step occurs at the following wrap.

Source files
------------

// File: rtl/pwm_breath_pkg.sv
// rtl/pwm_breath_pkg.sv - shared state encoding and width constants for the breathing PWM
package pwm_breath_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] DUTY_MAX = 8'd255;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_e;

endpackage

// File: rtl/pwm_cmp.sv
// rtl/pwm_cmp.sv - registered duty comparator producing the PWM waveform, gated by enable
module pwm_cmp
  import pwm_breath_pkg::*;
(
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic [CNT_W-1:0] duty,
  output logic             pwm_out
);

  logic pwm_q;

  // High while the period count is below the duty; forced low whenever disabled.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= en && (cnt_in < duty);
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_breath.sv
// rtl/pwm_breath.sv - breathing PWM ramp FSM; BREATH_HOLD_EN adds dwell periods at full/zero duty
module pwm_breath
  import pwm_breath_pkg::*;
#(
  parameter int STEP         = 1,
  parameter int HOLD_PERIODS = 16
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt_in,
  output logic             pwm_out,
  output logic [CNT_W-1:0] duty,
  output logic             period_tick,
  output logic             dir
);

  if (STEP < 1 || STEP > 128) begin : g_bad_step
    $error("pwm_breath: STEP out of range 1..128");
  end
  if (HOLD_PERIODS < 1 || HOLD_PERIODS > 255) begin : g_bad_hold
    $error("pwm_breath: HOLD_PERIODS out of range 1..255");
  end

  state_e           state_q;
  logic [CNT_W-1:0] duty_q;
  logic             dir_q;
  logic             tick_q;

  // The last count of a period: duty steps here so the new value applies from count 0.
  logic wrap;
  assign wrap = (cnt_in == DUTY_MAX);

  // Nine-bit arithmetic exposes overflow/borrow in bit 8 so saturation never wraps.
  logic [CNT_W:0] sum9;
  logic [CNT_W:0] diff9;
  assign sum9  = {1'b0, duty_q} + 9'(STEP);
  assign diff9 = {1'b0, duty_q} - 9'(STEP);

`ifdef BREATH_HOLD_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_PERIODS - 1);
  logic [7:0] hold_q;
`endif

  // Ramp FSM: period tick, duty stepping, direction and (optionally) dwell counting.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      tick_q  <= 1'b0;
`ifdef BREATH_HOLD_EN
      hold_q  <= '0;
`endif
    end else if (!en) begin
      state_q <= IDLE;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      tick_q  <= 1'b0;
`ifdef BREATH_HOLD_EN
      hold_q  <= '0;
`endif
    end else begin
      tick_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Entering from idle never steps, even if this cycle is the wrap count.
          state_q <= RISE;
          duty_q  <= '0;
          dir_q   <= 1'b0;
        end
        RISE: begin
          if (wrap) begin
            tick_q <= 1'b1;
            if (sum9[CNT_W]) begin
              duty_q <= DUTY_MAX;
              dir_q  <= 1'b1;
`ifdef BREATH_HOLD_EN
              hold_q  <= '0;
              state_q <= HOLD_HI;
`else
              state_q <= FALL;
`endif
            end else begin
              duty_q <= sum9[CNT_W-1:0];
            end
          end
        end
        FALL: begin
          if (wrap) begin
            tick_q <= 1'b1;
            if (diff9[CNT_W]) begin
              duty_q <= '0;
              dir_q  <= 1'b0;
`ifdef BREATH_HOLD_EN
              hold_q  <= '0;
              state_q <= HOLD_LO;
`else
              state_q <= RISE;
`endif
            end else begin
              duty_q <= diff9[CNT_W-1:0];
            end
          end
        end
`ifdef BREATH_HOLD_EN
        HOLD_HI: begin
          // The exiting tick already takes the first downward step.
          if (wrap) begin
            tick_q <= 1'b1;
            if (hold_q == HOLD_LAST) begin
              hold_q  <= '0;
              duty_q  <= diff9[CNT_W-1:0];
              state_q <= FALL;
            end else begin
              hold_q <= hold_q + 8'd1;
            end
          end
        end
        HOLD_LO: begin
          if (wrap) begin
            tick_q <= 1'b1;
            if (hold_q == HOLD_LAST) begin
              hold_q  <= '0;
              duty_q  <= sum9[CNT_W-1:0];
              state_q <= RISE;
            end else begin
              hold_q <= hold_q + 8'd1;
            end
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          duty_q  <= '0;
          dir_q   <= 1'b0;
        end
      endcase
    end
  end

  pwm_cmp u_cmp (
    .sclk    (sclk),
    .rst_n   (rst_n),
    .en      (en),
    .cnt_in  (cnt_in),
    .duty    (duty_q),
    .pwm_out (pwm_out)
  );

  assign duty        = duty_q;
  assign period_tick = tick_q;
  assign dir         = dir_q;

endmodule

// File: tb/tb_pwm_breath.sv
// tb/tb_pwm_breath.sv - self-checking bench for pwm_breath at STEP 1, 16 and 128
module tb_pwm_breath;

`ifdef BREATH_HOLD_EN
  localparam int EH = 1;
`else
  localparam int EH = 0;
`endif

  logic             sclk;
  logic             rst_n;
  logic             en;
  logic [7:0]       cnt_in;
  logic [2:0]       o_pwm, o_tick, o_dir;
  logic [2:0][7:0]  o_duty;

  int n_assert = 0;
  int n_fail   = 0;
  bit mon_on   = 0;

  pwm_breath #(.STEP(1), .HOLD_PERIODS(2)) u_s1 (
    .sclk(sclk), .rst_n(rst_n), .en(en), .cnt_in(cnt_in),
    .pwm_out(o_pwm[0]), .duty(o_duty[0]), .period_tick(o_tick[0]), .dir(o_dir[0]));
  pwm_breath #(.STEP(16), .HOLD_PERIODS(2)) u_s16 (
    .sclk(sclk), .rst_n(rst_n), .en(en), .cnt_in(cnt_in),
    .pwm_out(o_pwm[1]), .duty(o_duty[1]), .period_tick(o_tick[1]), .dir(o_dir[1]));
  pwm_breath #(.STEP(128), .HOLD_PERIODS(2)) u_s128 (
    .sclk(sclk), .rst_n(rst_n), .en(en), .cnt_in(cnt_in),
    .pwm_out(o_pwm[2]), .duty(o_duty[2]), .period_tick(o_tick[2]), .dir(o_dir[2]));

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  function automatic int step_of(int i);
    return (i == 0) ? 1 : (i == 1) ? 16 : 128;
  endfunction

  // Triangle wave as a closed-form sequence of per-tick duty values after leaving idle:
  // n rising multiples, a saturating 255, EH dwell repeats, n falling values, a saturating 0, EH dwell zeros.
  function automatic logic [7:0] f_duty(int s, int k);
    int n = 255 / s;
    int len = 2 * (n + 1) + 2 * EH;
    int p = k % len;
    if (p < n) return 8'((p + 1) * s);
    if (p < n + 1 + EH) return 8'd255;
    p = p - (n + 1 + EH);
    if (p < n) return 8'(255 - (p + 1) * s);
    return 8'd0;
  endfunction

  function automatic logic f_dir(int s, int k);
    int n = 255 / s;
    int len = 2 * (n + 1) + 2 * EH;
    int p = k % len;
    if (p < n) return 1'b0;
    if (p < n + 1 + EH) return 1'b1;
    p = p - (n + 1 + EH);
    return (p < n);
  endfunction

  logic [7:0] m_duty [3];
  logic       m_dir  [3];
  logic       m_tick [3];
  logic       m_pwm  [3];
  logic       m_act  [3];
  int         m_idx  [3];

  // Reference model: tick count since leaving idle indexes the triangle sequence.
  always @(posedge sclk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_act[i] <= 1'b0; m_idx[i] <= 0; m_duty[i] <= 8'd0;
        m_dir[i] <= 1'b0; m_tick[i] <= 1'b0; m_pwm[i] <= 1'b0;
      end else begin
        m_pwm[i] <= en && (cnt_in < m_duty[i]);
        if (!en) begin
          m_act[i] <= 1'b0; m_idx[i] <= 0; m_duty[i] <= 8'd0;
          m_dir[i] <= 1'b0; m_tick[i] <= 1'b0;
        end else if (!m_act[i]) begin
          m_act[i] <= 1'b1; m_idx[i] <= 0; m_duty[i] <= 8'd0;
          m_dir[i] <= 1'b0; m_tick[i] <= 1'b0;
        end else if (cnt_in == 8'd255) begin
          m_tick[i] <= 1'b1;
          m_duty[i] <= f_duty(step_of(i), m_idx[i]);
          m_dir[i]  <= f_dir(step_of(i), m_idx[i]);
          m_idx[i]  <= m_idx[i] + 1;
        end else begin
          m_tick[i] <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Per-cycle comparison of every instance against the model, away from the active edge.
  always @(negedge sclk) begin
    if (mon_on) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("duty_s%0d", step_of(i)), {1'b0, o_duty[i]}, {1'b0, m_duty[i]});
        check($sformatf("dir_s%0d", step_of(i)),  {8'd0, o_dir[i]},  {8'd0, m_dir[i]});
        check($sformatf("tick_s%0d", step_of(i)), {8'd0, o_tick[i]}, {8'd0, m_tick[i]});
        check($sformatf("pwm_s%0d", step_of(i)),  {8'd0, o_pwm[i]},  {8'd0, m_pwm[i]});
      end
    end
  end

  task automatic tick_clk();
    @(posedge sclk);
    #1;
    cnt_in = cnt_in + 8'd1;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_pwm%0d", tag, i),  {8'd0, o_pwm[i]},  9'd0);
      check($sformatf("%s_duty%0d", tag, i), {1'b0, o_duty[i]}, 9'd0);
      check($sformatf("%s_tick%0d", tag, i), {8'd0, o_tick[i]}, 9'd0);
      check($sformatf("%s_dir%0d", tag, i),  {8'd0, o_dir[i]},  9'd0);
    end
  endtask

  initial begin
    bit found;
    rst_n  = 1'b0;
    en     = 1'b1;
    cnt_in = 8'd0;
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 1'b0; m_idx[i] = 0; m_duty[i] = 8'd0;
      m_dir[i] = 1'b0; m_tick[i] = 1'b0; m_pwm[i] = 1'b0;
    end

    // Reset held for three cycles while the count runs.
    tick_clk();
    mon_on = 1'b1;
    check_all_zero("in_reset");
    tick_clk();
    tick_clk();
    rst_n = 1'b1;

    // Ramp STEP=1 up to duty 100, then drop enable at count 50.
    found = 1'b0;
    for (int c = 0; c < 130 * 256 && !found; c++) begin
      tick_clk();
      if (o_duty[0] == 8'd100 && cnt_in == 8'd50) found = 1'b1;
    end
    check("reach_duty100", {8'd0, found}, 9'd1);
    check("pwm_high_at_duty100", {8'd0, o_pwm[0]}, 9'd1);
    en = 1'b0;
    tick_clk();
    check_all_zero("en_drop");
    tick_clk();

    // Re-enable on the wrap count: no step on that edge, first step at the next wrap.
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      tick_clk();
      if (cnt_in == 8'd255) found = 1'b1;
    end
    check("find_wrap", {8'd0, found}, 9'd1);
    en = 1'b1;
    tick_clk();
    check_all_zero("en_on_wrap");
    repeat (255) tick_clk();
    tick_clk();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("first_step_tick%0d", i), {8'd0, o_tick[i]}, 9'd1);
      check($sformatf("first_step_duty%0d", i), {1'b0, o_duty[i]}, 9'(step_of(i)));
      check($sformatf("first_step_dir%0d", i),  {8'd0, o_dir[i]},  9'd0);
    end

    // Long free run covering full triangles of the STEP=16 and STEP=128 instances.
    repeat (40 * 256) tick_clk();

    // Randomly timed enable drops.
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(50, 700)) tick_clk();
      en = 1'b0;
      repeat ($urandom_range(1, 5)) tick_clk();
      en = 1'b1;
    end

    // Asynchronous reset mid-ramp, visible before the next clock edge.
    repeat ($urandom_range(300, 3000)) tick_clk();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    tick_clk();
    tick_clk();
    rst_n = 1'b1;
    repeat (6 * 256) tick_clk();

    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
